gpr_write_arbiter: RTL

Shares the single GPR write port between the in-order WriteBack stage and the long-latency multiply/divide unit, whose results return out of order. Aux results are buffered in a small in-order FIFO. WB normally wins the port, and WAW ordering is enforced by killing stale buffered writes. A starvation limiter stalls the pipe so buffered results drain. Also reports pending-write RAW hits for the decode-stage interlock.

---
 rtl/gpr_write_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gpr_write_arbiter.sv
// Arbitrates the single GPR write port between the in-order WB stage and a
// buffered, out-of-order aux (mul/div) result stream, with WAW kill and anti-starvation.
module gpr_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wbValid,
    input  logic [4:0]                   wbRegister,
    input  logic [31:0]                  wbData,
    input  logic                         auxValid,
    output logic                         auxReady,
    input  logic [4:0]                   auxRegister,
    input  logic [31:0]                  auxData,
    output logic                         pipeStall,
    output logic                         gprWriteEnabled,
    output logic [4:0]                   gprWriteRegister,
    output logic [31:0]                  gprWriteInput,
    input  logic [4:0]                   queryRegister,
    output logic                         pendingHit,
    output logic [$clog2(DEPTH+1)-1:0]   pendingCount
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [4:0]       fifo_reg  [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_kill;
    logic [DEPTH-1:0] kill_nxt;
    logic [DEPTH-1:0] occ;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [SW-1:0]    starve;
    logic [SW-1:0]    starve_nxt;

    logic wb_req;
    logic grant_wb;
    logic grant_aux;
    logic pop;
    logic enq;
    logic enq_kill;

    assign wb_req       = wbValid && (wbRegister != 5'd0);
    assign enq          = auxValid && auxReady;
    assign pendingCount = count;

    // One grant per cycle; a killed head is dropped while WB still uses the port.
    always_comb begin
        grant_wb  = 1'b0;
        grant_aux = 1'b0;
        pop       = 1'b0;
        pipeStall = 1'b0;
        if (count == '0) begin
            grant_wb = wb_req;
        end else if (fifo_kill[rd_ptr]) begin
            pop      = 1'b1;
            grant_wb = wb_req;
        end else if (!wb_req) begin
            grant_aux = 1'b1;
            pop       = 1'b1;
        end else if (starve < SW'(STARVE_LIMIT)) begin
            grant_wb = 1'b1;
        end else begin
            grant_aux = 1'b1;
            pop       = 1'b1;
            pipeStall = 1'b1;
        end
    end

    always_comb begin
        starve_nxt = starve;
        if ((count == '0) || grant_aux) begin
            starve_nxt = '0;
        end else if (grant_wb && !fifo_kill[rd_ptr] && (starve < SW'(STARVE_LIMIT))) begin
            starve_nxt = starve + SW'(1);
        end
    end

    assign count_nxt = count + CW'(enq) - CW'(pop);
    assign enq_kill  = (auxRegister == 5'd0) || (grant_wb && (auxRegister == wbRegister));

    // Occupancy is relative to the read pointer; WB grants kill older same-register entries.
    always_comb begin
        kill_nxt   = fifo_kill;
        pendingHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
            if (grant_wb && occ[i] && (fifo_reg[i] == wbRegister)) begin
                kill_nxt[i] = 1'b1;
            end
            if (occ[i] && !fifo_kill[i] && (queryRegister != 5'd0)
                && (fifo_reg[i] == queryRegister)) begin
                pendingHit = 1'b1;
            end
        end
        if (enq) begin
            kill_nxt[wr_ptr] = enq_kill;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            starve           <= '0;
            fifo_kill        <= '0;
            auxReady         <= 1'b0;
            gprWriteEnabled  <= 1'b0;
            gprWriteRegister <= '0;
            gprWriteInput    <= '0;
        end else begin
            count     <= count_nxt;
            starve    <= starve_nxt;
            fifo_kill <= kill_nxt;
            auxReady  <= count_nxt < CW'(DEPTH);
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            gprWriteEnabled <= grant_wb || grant_aux;
            if (grant_wb) begin
                gprWriteRegister <= wbRegister;
                gprWriteInput    <= wbData;
            end else if (grant_aux) begin
                gprWriteRegister <= fifo_reg[rd_ptr];
                gprWriteInput    <= fifo_data[rd_ptr];
            end
        end
    end

    // Payload storage needs no reset; occupancy and kill flags qualify it.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_reg[wr_ptr]  <= auxRegister;
            fifo_data[wr_ptr] <= auxData;
        end
    end

endmodule
